toggle_bank: RTL and testbench

//  Parametrised bank of CH independent synchronous toggle channels driven by a per-channel 2-bit opcode.

---
 rtl/toggle_pkg.sv | 21 ++
 rtl/toggle_cell.sv | 70 +++++++
 rtl/toggle_bank.sv | 45 ++++
 tb/tb_toggle_bank.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/toggle_pkg.sv
// rtl/toggle_pkg.sv - opcodes and sizing helper shared by the toggle bank
//
// Purpose : per-channel opcode encodings and the prescaler width function.
// Ports   : none (package).

package toggle_pkg;

  localparam logic [1:0] OP_HOLD   = 2'b00;
  localparam logic [1:0] OP_TOGGLE = 2'b01;
  localparam logic [1:0] OP_SET    = 2'b10;
  localparam logic [1:0] OP_CLEAR  = 2'b11;

  // Prescaler width is max(1, clog2(div)); DIV=1 still gets a 1-bit register
  // that simply never leaves zero.
  function automatic int pre_width(input int div);
    int w;
    w = $clog2(div);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/toggle_cell.sv
// rtl/toggle_cell.sv - one toggle channel: opcode decode, prescaler, counter, sticky saturation
//
// Purpose : a single independent channel of the toggle bank.
// Ports   : clk       rising-edge clock
//           rst       synchronous reset, active-high
//           en        global enable; 0 holds all state
//           op[1:0]   HOLD / TOGGLE / SET / CLEAR
//           tog       channel output state
//           cnt       completed flips since last CLEAR/rst, saturating
//           sat       sticky: cnt tried to go past its maximum

import toggle_pkg::*;

module toggle_cell #(
  parameter int DIV       = 1,
  parameter int CNT_W     = 8,
  parameter bit RESET_BIT = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       op,
  output logic             tog,
  output logic [CNT_W-1:0] cnt,
  output logic             sat
);

  localparam int            PW       = pre_width(DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

  logic [PW-1:0] pre;

  always_ff @(posedge clk) begin
    if (rst) begin
      tog <= RESET_BIT;
      pre <= '0;
      cnt <= '0;
      sat <= 1'b0;
    end else if (en) begin
      // Every arm assigns only what it changes; HOLD and X/Z opcodes fall
      // through with no assignment, so state is clock-enabled, never latched.
      case (op)
        OP_HOLD: ;
        OP_TOGGLE: begin
          if (pre == PRE_LAST) begin
            pre <= '0;
            tog <= ~tog;
            // The flip that would overflow still happens; the count pins.
            if (cnt == {CNT_W{1'b1}}) sat <= 1'b1;
            else                      cnt <= cnt + CNT_W'(1);
          end else begin
            pre <= pre + PW'(1);
          end
        end
        OP_SET: begin
          tog <= 1'b1;
          pre <= '0;
        end
        OP_CLEAR: begin
          tog <= 1'b0;
          pre <= '0;
          cnt <= '0;
          sat <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/toggle_bank.sv
// rtl/toggle_bank.sv - bank of CH independent toggle channels
//
// Purpose : replicates toggle_cell CH times and slices the packed ports.
// Ports   : clk                     rising-edge clock
//           rst                     synchronous reset, active-high
//           en                      global enable
//           op[2*CH-1:0]            opcode of ch i at [2i+1:2i]
//           toggle_out[CH-1:0]      channel states
//           toggle_cnt[CH*CNT_W-1:0] ch i at [CNT_W*i +: CNT_W]
//           sat[CH-1:0]             sticky per-channel saturation

import toggle_pkg::*;

module toggle_bank #(
  parameter int            CH        = 4,
  parameter int            DIV       = 1,
  parameter int            CNT_W     = 8,
  parameter logic [CH-1:0] RESET_VAL = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [2*CH-1:0]     op,
  output logic [CH-1:0]       toggle_out,
  output logic [CH*CNT_W-1:0] toggle_cnt,
  output logic [CH-1:0]       sat
);

  for (genvar i = 0; i < CH; i++) begin : g_ch
    toggle_cell #(
      .DIV       (DIV),
      .CNT_W     (CNT_W),
      .RESET_BIT (RESET_VAL[i])
    ) u_cell (
      .clk (clk),
      .rst (rst),
      .en  (en),
      .op  (op[2*i +: 2]),
      .tog (toggle_out[i]),
      .cnt (toggle_cnt[CNT_W*i +: CNT_W]),
      .sat (sat[i])
    );
  end

endmodule

// File: tb/tb_toggle_bank.sv
// tb/tb_toggle_bank.sv - self-checking bench for toggle_bank against a behavioural model

module tb_toggle_bank;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [7:0] op  = 8'h00;

  logic [3:0]  a_out, b_out, c_out;
  logic [31:0] a_cnt, b_cnt;
  logic [7:0]  c_cnt;
  logic [3:0]  a_sat, b_sat, c_sat;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // a: defaults; b: DIV=3; c: CNT_W=2 with RESET_VAL=4'b0101
  toggle_bank #(.CH(4), .DIV(1), .CNT_W(8), .RESET_VAL(4'b0000)) dut_a (
    .clk(clk), .rst(rst), .en(en), .op(op),
    .toggle_out(a_out), .toggle_cnt(a_cnt), .sat(a_sat));
  toggle_bank #(.CH(4), .DIV(3), .CNT_W(8), .RESET_VAL(4'b0000)) dut_b (
    .clk(clk), .rst(rst), .en(en), .op(op),
    .toggle_out(b_out), .toggle_cnt(b_cnt), .sat(b_sat));
  toggle_bank #(.CH(4), .DIV(1), .CNT_W(2), .RESET_VAL(4'b0101)) dut_c (
    .clk(clk), .rst(rst), .en(en), .op(op),
    .toggle_out(c_out), .toggle_cnt(c_cnt), .sat(c_sat));

  // Model: per instance/channel, output bit, accepted toggles in the current
  // DIV window, and an unbounded flip count since the last CLEAR/rst.
  int         divs [3] = '{1, 3, 1};
  int         maxs [3] = '{255, 255, 3};
  int         wids [3] = '{8, 8, 2};
  logic [3:0] rvs  [3] = '{4'b0000, 4'b0000, 4'b0101};
  int m_out [3][4];
  int m_win [3][4];
  int m_flp [3][4];

  task automatic model_step();
    logic [1:0] o;
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < 4; c++) begin
        if (rst === 1'b1) begin
          m_out[k][c] = int'(rvs[k][c]);
          m_win[k][c] = 0;
          m_flp[k][c] = 0;
        end else if (en === 1'b1) begin
          o = op[2*c +: 2];
          if (o === 2'b01) begin
            m_win[k][c] = m_win[k][c] + 1;
            if (m_win[k][c] == divs[k]) begin
              m_win[k][c] = 0;
              m_out[k][c] = 1 - m_out[k][c];
              m_flp[k][c] = m_flp[k][c] + 1;
            end
          end else if (o === 2'b10) begin
            m_out[k][c] = 1;
            m_win[k][c] = 0;
          end else if (o === 2'b11) begin
            m_out[k][c] = 0;
            m_win[k][c] = 0;
            m_flp[k][c] = 0;
          end
        end
      end
    end
  endtask

  function automatic logic [31:0] e_out(int k);
    logic [31:0] v = 0;
    for (int c = 0; c < 4; c++) if (m_out[k][c] != 0) v[c] = 1'b1;
    return v;
  endfunction

  function automatic logic [31:0] e_cnt(int k);
    logic [31:0] v = 0;
    int n;
    for (int c = 0; c < 4; c++) begin
      n = (m_flp[k][c] > maxs[k]) ? maxs[k] : m_flp[k][c];
      v = v | (32'(n) << (c * wids[k]));
    end
    return v;
  endfunction

  function automatic logic [31:0] e_sat(int k);
    logic [31:0] v = 0;
    for (int c = 0; c < 4; c++) if (m_flp[k][c] > maxs[k]) v[c] = 1'b1;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("a_out", 32'(a_out), e_out(0));
    chk("a_cnt", a_cnt,      e_cnt(0));
    chk("a_sat", 32'(a_sat), e_sat(0));
    chk("b_out", 32'(b_out), e_out(1));
    chk("b_cnt", b_cnt,      e_cnt(1));
    chk("b_sat", 32'(b_sat), e_sat(1));
    chk("c_out", 32'(c_out), e_out(2));
    chk("c_cnt", 32'(c_cnt), e_cnt(2));
    chk("c_sat", 32'(c_sat), e_sat(2));
  endtask

  // Drive at the falling edge, advance one rising edge, compare at the next fall.
  task automatic step(input logic r, input logic e, input logic [7:0] o);
    rst = r; en = e; op = o;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  int lit_c1 [5] = '{1, 2, 3, 3, 3};
  int lit_s1 [5] = '{0, 0, 0, 1, 1};
  int lit_o1 [5] = '{1, 0, 1, 0, 1};

  initial begin
    logic [7:0] o;
    logic       r, e;
    int         ch;

    // 1: reset then idle
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 8'h00);
    chk("lit_idle_a_out", 32'(a_out), 32'h0);
    chk("lit_idle_a_cnt", a_cnt, 32'h0);
    chk("lit_idle_c_out", 32'(c_out), 32'h5);

    // 2: ch0 toggles on DIV=1
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 8'h01);
      chk("lit_s2_out0", 32'(a_out[0]), (i == 1) ? 32'd0 : 32'd1);
      chk("lit_s2_cnt0", 32'(a_cnt[7:0]), 32'(i + 1));
    end
    chk("lit_s2_others", 32'(a_out[3:1]), 32'h0);

    // 3: DIV=3 prescale, reset discards a partial window
    step(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, 8'h01);
      if (i == 2) chk("lit_s3_rise", 32'(b_out[0]), 32'd1);
    end
    chk("lit_s3_fall", 32'(b_out[0]), 32'd0);
    chk("lit_s3_cnt0", 32'(b_cnt[7:0]), 32'd2);
    step(1'b0, 1'b1, 8'h01);
    step(1'b0, 1'b1, 8'h01);
    step(1'b1, 1'b1, 8'h01);
    step(1'b0, 1'b1, 8'h01);
    chk("lit_s3_rst_pre", 32'(b_out[0]), 32'd0);
    step(1'b0, 1'b1, 8'h01);
    step(1'b0, 1'b1, 8'h01);
    chk("lit_s3_after3", 32'(b_out[0]), 32'd1);

    // 4: CNT_W=2 saturation on ch1, then CLEAR
    step(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 8'h04);
      chk("lit_s4_cnt1", 32'(c_cnt[3:2]), 32'(lit_c1[i]));
      chk("lit_s4_sat1", 32'(c_sat[1]),   32'(lit_s1[i]));
      chk("lit_s4_out1", 32'(c_out[1]),   32'(lit_o1[i]));
    end
    step(1'b0, 1'b1, 8'h0C);
    chk("lit_s4_clr", {29'd0, c_out[1], c_sat[1], 1'b0} | 32'(c_cnt[3:2]), 32'h0);

    // 5: mixed ops in one cycle, then global enable low
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'hA0);
    chk("lit_s5_pre", 32'(a_out), 32'hC);
    step(1'b0, 1'b1, 8'b00_11_10_01);
    chk("lit_s5_mix", 32'(a_out), 32'hB);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 8'h55);
    chk("lit_s5_hold", 32'(a_out), 32'hB);

    // 6: reset mid-stream to a non-zero RESET_VAL, then X opcodes
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h55);
    step(1'b1, 1'b1, 8'h55);
    chk("lit_s6_out", 32'(c_out), 32'h5);
    chk("lit_s6_cnt", 32'(c_cnt), 32'h0);
    step(1'b0, 1'b1, 8'hxx);
    step(1'b0, 1'b1, 8'hxx);
    chk("lit_s6_x_out", 32'(c_out), 32'h5);
    chk("lit_s6_x_cnt", 32'(c_cnt), 32'h0);

    // Randomised traffic, biased toward TOGGLE so the 2-bit counters saturate.
    for (int i = 0; i < 600; i++) begin
      r = ($urandom_range(0, 59) == 0);
      e = ($urandom_range(0, 7) != 0);
      for (int c = 0; c < 4; c++) begin
        case ($urandom_range(0, 9))
          0, 1:    o[2*c +: 2] = 2'b00;
          7:       o[2*c +: 2] = 2'b10;
          8:       o[2*c +: 2] = ($urandom_range(0, 3) == 0) ? 2'b11 : 2'b01;
          9:       o[2*c +: 2] = ($urandom_range(0, 4) == 0) ? 2'bxx : 2'b01;
          default: o[2*c +: 2] = 2'b01;
        endcase
      end
      ch = $urandom_range(0, 3);
      if ($urandom_range(0, 99) == 0) o[2*ch +: 2] = 2'b11;
      step(r, e, o);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
